// File: rtl/ahb_arb_pkg.sv
// Shared AHB-Lite encodings, arbiter state type and burst-length decode
// for ahb_bus_arbiter.
package ahb_arb_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_e;

    typedef enum logic [2:0] {
        HBURST_SINGLE = 3'b000,
        HBURST_INCR   = 3'b001,
        HBURST_WRAP4  = 3'b010,
        HBURST_INCR4  = 3'b011,
        HBURST_WRAP8  = 3'b100,
        HBURST_INCR8  = 3'b101,
        HBURST_WRAP16 = 3'b110,
        HBURST_INCR16 = 3'b111
    } hburst_e;

    typedef enum logic [1:0] {
        HRESP_OKAY  = 2'b00,
        HRESP_ERROR = 2'b01,
        HRESP_RETRY = 2'b10,
        HRESP_SPLIT = 2'b11
    } hresp_e;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_BURST,
        ARB_INCR
    } arb_state_e;

    // Beats in a burst; 0 marks the undefined-length INCR burst.
    function automatic logic [4:0] burst_len(input logic [2:0] hburst);
        case (hburst)
            HBURST_SINGLE:               return 5'd1;
            HBURST_INCR:                 return 5'd0;
            HBURST_WRAP4, HBURST_INCR4:  return 5'd4;
            HBURST_WRAP8, HBURST_INCR8:  return 5'd8;
            default:                     return 5'd16;
        endcase
    endfunction

endpackage

// File: rtl/ahb_bus_arbiter_rr_picker.sv
// Combinational round-robin picker: first set request strictly after the
// pointer (wrapping), returned as one-hot grant plus index.
module rr_picker #(
    parameter int NUM_MASTERS = 4,
    parameter int MIDX_W      = $clog2(NUM_MASTERS)
) (
    input  logic [NUM_MASTERS-1:0] req,
    input  logic [MIDX_W-1:0]      ptr,
    output logic [NUM_MASTERS-1:0] gnt,
    output logic [MIDX_W-1:0]      idx,
    output logic                   valid
);

    function automatic logic [MIDX_W-1:0] wrap_idx(input int base, input int off);
        return MIDX_W'((base + off) % NUM_MASTERS);
    endfunction

    // Walk from farthest to nearest so the nearest requester overwrites last.
    always_comb begin
        idx   = '0;
        valid = 1'b0;
        for (int i = NUM_MASTERS; i >= 1; i--) begin
            if (req[wrap_idx(int'(ptr), i)]) begin
                idx   = wrap_idx(int'(ptr), i);
                valid = 1'b1;
            end
        end
    end

    assign gnt = valid ? (NUM_MASTERS'(1) << idx) : '0;

endmodule

// File: rtl/ahb_bus_arbiter.sv
// Round-robin AHB-Lite arbiter with burst tracking and registered grant.
// Optional bus locking is enabled with the AHB_ARB_LOCK_EN macro.
module ahb_bus_arbiter
    import ahb_arb_pkg::*;
#(
    parameter int NUM_MASTERS    = 4,
    parameter int MIDX_W         = $clog2(NUM_MASTERS),
    parameter int DEFAULT_MASTER = 0
) (
    input  logic                   hclk,
    input  logic                   hreset,
    input  logic [NUM_MASTERS-1:0] hbusreq,
    input  logic [NUM_MASTERS-1:0] hlock,
    input  logic [1:0]             htrans,
    input  logic [2:0]             hburst,
    input  logic                   hreadyout,
    input  logic [1:0]             hresp,
    output logic [NUM_MASTERS-1:0] hgrant,
    output logic [MIDX_W-1:0]      hmaster,
    output logic [MIDX_W-1:0]      hmaster_data,
    output logic                   hmastlock
);

    localparam logic [MIDX_W-1:0]      DEF_IDX = MIDX_W'(DEFAULT_MASTER);
    localparam logic [NUM_MASTERS-1:0] DEF_GNT = NUM_MASTERS'(1) << DEFAULT_MASTER;

    arb_state_e             state_q, state_d;
    logic [4:0]             count_q, count_d;
    logic [MIDX_W-1:0]      ptr_q, ptr_d;
    logic [NUM_MASTERS-1:0] hgrant_q, hgrant_d;
    logic [MIDX_W-1:0]      hmaster_q, hmaster_d;
    logic [MIDX_W-1:0]      hmaster_data_q, hmaster_data_d;
    logic                   hmastlock_q, hmastlock_d;

    logic [NUM_MASTERS-1:0] pick_gnt;
    logic [MIDX_W-1:0]      pick_idx;
    logic                   pick_valid;
    logic [4:0]             blen;
    logic                   owner_req;
    logic                   regrant;
    logic                   take_pick;

    rr_picker #(
        .NUM_MASTERS (NUM_MASTERS),
        .MIDX_W      (MIDX_W)
    ) u_picker (
        .req   (hbusreq),
        .ptr   (ptr_q),
        .gnt   (pick_gnt),
        .idx   (pick_idx),
        .valid (pick_valid)
    );

    assign blen      = burst_len(hburst);
    assign owner_req = hbusreq[hmaster_q];

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        regrant = 1'b0;
        case (state_q)
            ARB_IDLE: begin
                if (htrans == HTRANS_NONSEQ && blen > 5'd1) begin
                    state_d = ARB_BURST;
                    count_d = blen - 5'd1;
                end else if (htrans == HTRANS_NONSEQ && blen == 5'd0) begin
                    state_d = ARB_INCR;
                end else begin
                    regrant = 1'b1;
                end
            end
            ARB_BURST: begin
                if (htrans == HTRANS_SEQ) begin
                    if (count_q <= 5'd1) begin
                        state_d = ARB_IDLE;
                        count_d = '0;
                        regrant = 1'b1;
                    end else begin
                        count_d = count_q - 5'd1;
                    end
                end else if (htrans != HTRANS_BUSY) begin
                    // Owner abandoned the burst early; free the bus.
                    state_d = ARB_IDLE;
                    count_d = '0;
                    regrant = 1'b1;
                end
            end
            ARB_INCR: begin
                if (!(owner_req || htrans == HTRANS_SEQ || htrans == HTRANS_BUSY)) begin
                    state_d = ARB_IDLE;
                    regrant = 1'b1;
                end
            end
            default: begin
                state_d = ARB_IDLE;
                count_d = '0;
                regrant = 1'b1;
            end
        endcase
        if (hresp != HRESP_OKAY) begin
            state_d = ARB_IDLE;
            count_d = '0;
            regrant = 1'b1;
        end
    end

    always_comb begin
        hgrant_d       = hgrant_q;
        hmaster_d      = hmaster_q;
        ptr_d          = ptr_q;
        hmastlock_d    = hmastlock_q;
        hmaster_data_d = hmaster_q;
        take_pick      = 1'b0;
        if (regrant) begin
            hmastlock_d = 1'b0;
`ifdef AHB_ARB_LOCK_EN
            if (hlock[hmaster_q]) begin
                hmastlock_d = 1'b1;
            end else begin
                take_pick = 1'b1;
            end
`else
            take_pick = 1'b1;
`endif
        end
        if (take_pick) begin
            if (pick_valid) begin
                hgrant_d  = pick_gnt;
                hmaster_d = pick_idx;
                ptr_d     = pick_idx;
            end else begin
                hgrant_d  = DEF_GNT;
                hmaster_d = DEF_IDX;
            end
        end
    end

    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            state_q        <= ARB_IDLE;
            count_q        <= '0;
            ptr_q          <= DEF_IDX;
            hgrant_q       <= DEF_GNT;
            hmaster_q      <= DEF_IDX;
            hmaster_data_q <= DEF_IDX;
            hmastlock_q    <= 1'b0;
        end else if (hreadyout) begin
            state_q        <= state_d;
            count_q        <= count_d;
            ptr_q          <= ptr_d;
            hgrant_q       <= hgrant_d;
            hmaster_q      <= hmaster_d;
            hmaster_data_q <= hmaster_data_d;
            hmastlock_q    <= hmastlock_d;
        end
    end

    assign hgrant       = hgrant_q;
    assign hmaster      = hmaster_q;
    assign hmaster_data = hmaster_data_q;

`ifdef AHB_ARB_LOCK_EN
    assign hmastlock = hmastlock_q;
`else
    logic unused_lock;
    assign unused_lock = ^{hlock, hmastlock_q};
    assign hmastlock   = 1'b0;
`endif

endmodule

// File: tb/tb_ahb_bus_arbiter.sv
// Scoreboard bench for ahb_bus_arbiter: directed bus cycles push expected
// outputs, a monitor pops and compares one entry after every clock edge.
module tb_ahb_bus_arbiter;

    localparam logic [1:0] T_IDLE = 2'b00;
    localparam logic [1:0] T_BUSY = 2'b01;
    localparam logic [1:0] T_NSEQ = 2'b10;
    localparam logic [1:0] T_SEQ  = 2'b11;
    localparam logic [2:0] B_SINGLE = 3'b000;
    localparam logic [2:0] B_INCR   = 3'b001;
    localparam logic [2:0] B_INCR4  = 3'b011;
    localparam logic [2:0] B_INCR8  = 3'b101;
    localparam logic [1:0] R_OK  = 2'b00;
    localparam logic [1:0] R_ERR = 2'b01;

    logic       hclk = 1'b0;
    logic       hreset = 1'b0;
    logic [3:0] hbusreq = '0;
    logic [3:0] hlock = '0;
    logic [1:0] htrans = T_IDLE;
    logic [2:0] hburst = B_SINGLE;
    logic       hreadyout = 1'b1;
    logic [1:0] hresp = R_OK;
    logic [3:0] hgrant;
    logic [1:0] hmaster;
    logic [1:0] hmaster_data;
    logic       hmastlock;

    ahb_bus_arbiter #(
        .NUM_MASTERS    (4),
        .MIDX_W         (2),
        .DEFAULT_MASTER (0)
    ) dut (
        .hclk         (hclk),
        .hreset       (hreset),
        .hbusreq      (hbusreq),
        .hlock        (hlock),
        .htrans       (htrans),
        .hburst       (hburst),
        .hreadyout    (hreadyout),
        .hresp        (hresp),
        .hgrant       (hgrant),
        .hmaster      (hmaster),
        .hmaster_data (hmaster_data),
        .hmastlock    (hmastlock)
    );

    always #5 hclk = ~hclk;

    typedef struct {
        logic [8:0] v;
        string      nm;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    function automatic void cmp(input string nm, input logic [8:0] act, input logic [8:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got hgrant=%b hmaster=%0d hmaster_data=%0d hmastlock=%b, expected hgrant=%b hmaster=%0d hmaster_data=%0d hmastlock=%b",
                     nm, act[8:5], act[4:3], act[2:1], act[0], exp[8:5], exp[4:3], exp[2:1], exp[0]);
        end
    endfunction

    task automatic step(input logic [3:0] req, input logic [1:0] tr, input logic [2:0] bu,
                        input logic rdy, input logic [1:0] rsp,
                        input logic [3:0] eg, input logic [1:0] em, input logic [1:0] emd,
                        input logic eml, input string nm);
        exp_t e;
        @(negedge hclk);
        hbusreq   = req;
        htrans    = tr;
        hburst    = bu;
        hreadyout = rdy;
        hresp     = rsp;
        e.v  = {eg, em, emd, eml};
        e.nm = nm;
        sb.push_back(e);
    endtask

    // Monitor: one expected entry per edge, compared just after the edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge hclk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                cmp(e.nm, {hgrant, hmaster, hmaster_data, hmastlock}, e.v);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, errors=%0d", errors);
        $fatal(1, "timeout");
    end

    initial begin
        #1 hreset = 1'b1;
        #2;
        cmp("reset_async", {hgrant, hmaster, hmaster_data, hmastlock}, {4'b0001, 2'd0, 2'd0, 1'b0});
        @(negedge hclk);
        hreset = 1'b0;

        step(4'b0000, T_IDLE, B_SINGLE, 1, R_OK, 4'b0001, 2'd0, 2'd0, 0, "park");

        // Round robin with SINGLE transfers.
        step(4'b1111, T_IDLE, B_SINGLE, 1, R_OK, 4'b0010, 2'd1, 2'd0, 0, "rr_1");
        step(4'b1111, T_NSEQ, B_SINGLE, 1, R_OK, 4'b0100, 2'd2, 2'd1, 0, "rr_2");
        step(4'b1111, T_NSEQ, B_SINGLE, 1, R_OK, 4'b1000, 2'd3, 2'd2, 0, "rr_3");
        step(4'b1111, T_NSEQ, B_SINGLE, 1, R_OK, 4'b0001, 2'd0, 2'd3, 0, "rr_4");

        // INCR8 by master 1 with wait states and a competing request.
        step(4'b0010, T_IDLE, B_INCR8, 1, R_OK, 4'b0010, 2'd1, 2'd0, 0, "b8_grant");
        step(4'b0010, T_NSEQ, B_INCR8, 1, R_OK, 4'b0010, 2'd1, 2'd1, 0, "b8_beat1");
        step(4'b0010, T_SEQ,  B_INCR8, 1, R_OK, 4'b0010, 2'd1, 2'd1, 0, "b8_beat2");
        step(4'b0110, T_SEQ,  B_INCR8, 1, R_OK, 4'b0010, 2'd1, 2'd1, 0, "b8_beat3");
        step(4'b0110, T_SEQ,  B_INCR8, 0, R_OK, 4'b0010, 2'd1, 2'd1, 0, "b8_wait1");
        step(4'b0110, T_SEQ,  B_INCR8, 0, R_OK, 4'b0010, 2'd1, 2'd1, 0, "b8_wait2");
        step(4'b0110, T_SEQ,  B_INCR8, 1, R_OK, 4'b0010, 2'd1, 2'd1, 0, "b8_beat4");
        step(4'b0100, T_SEQ,  B_INCR8, 1, R_OK, 4'b0010, 2'd1, 2'd1, 0, "b8_beat5_dropreq");
        step(4'b0100, T_SEQ,  B_INCR8, 1, R_OK, 4'b0010, 2'd1, 2'd1, 0, "b8_beat6");
        step(4'b0100, T_SEQ,  B_INCR8, 1, R_OK, 4'b0010, 2'd1, 2'd1, 0, "b8_beat7");
        step(4'b0100, T_SEQ,  B_INCR8, 1, R_OK, 4'b0100, 2'd2, 2'd1, 0, "b8_beat8_regrant");
        step(4'b0000, T_NSEQ, B_SINGLE, 1, R_OK, 4'b0001, 2'd0, 2'd2, 0, "no_req_default");

        // Undefined-length INCR by master 3, master 0 waiting.
        step(4'b1000, T_IDLE, B_INCR, 1, R_OK, 4'b1000, 2'd3, 2'd0, 0, "incr_grant");
        step(4'b1001, T_NSEQ, B_INCR, 1, R_OK, 4'b1000, 2'd3, 2'd3, 0, "incr_nseq");
        step(4'b1001, T_SEQ,  B_INCR, 1, R_OK, 4'b1000, 2'd3, 2'd3, 0, "incr_seq1");
        step(4'b1001, T_BUSY, B_INCR, 1, R_OK, 4'b1000, 2'd3, 2'd3, 0, "incr_busy");
        for (int i = 2; i <= 5; i++) begin
            step(4'b1001, T_SEQ, B_INCR, 1, R_OK, 4'b1000, 2'd3, 2'd3, 0, $sformatf("incr_seq%0d", i));
        end
        step(4'b1001, T_IDLE, B_INCR, 1, R_OK, 4'b1000, 2'd3, 2'd3, 0, "incr_idle_still_req");
        step(4'b0001, T_IDLE, B_INCR, 1, R_OK, 4'b0001, 2'd0, 2'd3, 0, "incr_release");

        // ERROR response on beat 2 of INCR4 aborts the burst.
        step(4'b0010, T_IDLE, B_INCR4, 1, R_OK,  4'b0010, 2'd1, 2'd0, 0, "err_grant");
        step(4'b0110, T_NSEQ, B_INCR4, 1, R_OK,  4'b0010, 2'd1, 2'd1, 0, "err_beat1");
        step(4'b0110, T_SEQ,  B_INCR4, 0, R_ERR, 4'b0010, 2'd1, 2'd1, 0, "err_first_cycle");
        step(4'b0110, T_SEQ,  B_INCR4, 1, R_ERR, 4'b0100, 2'd2, 2'd1, 0, "err_abort_regrant");
        step(4'b0001, T_BUSY, B_INCR4, 1, R_OK,  4'b0001, 2'd0, 2'd2, 0, "err_state_idle");
        step(4'b0001, T_NSEQ, B_SINGLE, 1, R_OK, 4'b0001, 2'd0, 2'd0, 0, "sole_owner_keeps");

        hlock = 4'b0001;
`ifdef AHB_ARB_LOCK_EN
        step(4'b0101, T_IDLE, B_INCR4, 1, R_OK, 4'b0001, 2'd0, 2'd0, 1, "lock_take");
        for (int b = 0; b < 2; b++) begin
            step(4'b0101, T_NSEQ, B_INCR4, 1, R_OK, 4'b0001, 2'd0, 2'd0, 1, "lock_nseq");
            for (int i = 0; i < 3; i++) begin
                step(4'b0101, T_SEQ, B_INCR4, 1, R_OK, 4'b0001, 2'd0, 2'd0, 1, "lock_seq");
            end
        end
        hlock = 4'b0000;
        step(4'b0101, T_IDLE, B_INCR4, 1, R_OK, 4'b0100, 2'd2, 2'd0, 0, "lock_release");
`else
        step(4'b0101, T_IDLE, B_INCR4, 1, R_OK, 4'b0100, 2'd2, 2'd0, 0, "lock_ignored");
        hlock = 4'b0000;
`endif

        // Reset in the middle of an INCR8 by master 2.
        step(4'b0100, T_NSEQ, B_INCR8, 1, R_OK, 4'b0100, 2'd2, 2'd2, 0, "rst_burst_nseq");
        step(4'b0100, T_SEQ,  B_INCR8, 1, R_OK, 4'b0100, 2'd2, 2'd2, 0, "rst_burst_seq");
        @(posedge hclk);
        #2;
        hreset = 1'b1;
        #1;
        cmp("reset_mid_burst", {hgrant, hmaster, hmaster_data, hmastlock}, {4'b0001, 2'd0, 2'd0, 1'b0});
        hbusreq = 4'b0010;
        htrans  = T_SEQ;
        #1;
        hreset = 1'b0;
        step(4'b0010, T_SEQ, B_INCR8, 1, R_OK, 4'b0010, 2'd1, 2'd0, 0, "post_reset_idle");

        @(posedge hclk);
        #3;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
